if_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the ID-stage decoder.
- Owns the PC register, next-PC selection (sequential / jump / branch), the instruction-memory request, and the IF/ID pipeline register.
- The decoder consumes op = ifid_instr[31:26] and funct = ifid_instr[5:0] from this stage.
- Responds to stall (hazard unit), jump redirect (ID) and branch redirect (EX).

---
 rtl/if_stage_pkg.sv | 19 +
 rtl/if_stage_ifid_reg.sv | 18 +
 rtl/if_stage.sv | 51 +++++
 tb/tb_if_stage.sv | 126 ++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared pipeline constants, opcode fields and the IF/ID bundle type
package if_stage_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J = 6'h02;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;
  localparam logic [5:0] FUNCT_SLL = 6'h00;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        valid;
  } ifid_t;
  typedef enum logic {RUN, WAIT_MEM} mode_t;
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/if_stage_ifid_reg.sv
// ifid_reg: pipeline register with flush (bubble, beats stall), hold on stall, and bubble insert
module ifid_reg import if_stage_pkg::*; #(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  flush,
  input  logic  stall,
  input  logic  bubble,
  input  ifid_t d,
  output ifid_t q
);
  localparam ifid_t EMPTY = '{instr: NOP_INSTR, pc_plus4: 32'h0, valid: 1'b0};
  always_ff @(posedge clk) begin
    if (rst || flush || (!stall && bubble)) q <= EMPTY;
    else if (!stall) q <= d;
  end
endmodule

// File: rtl/if_stage.sv
// if_stage: MIPS fetch stage owning the PC, next-PC select, imem request and the IF/ID register
module if_stage import if_stage_pkg::*; #(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid
);
  mode_t mode, mode_nxt;
  logic take_jump, redirect;
  logic [31:0] pc_plus4, pc_nxt;
  ifid_t ifid_d, ifid_q;
  // a stalled jump is dropped; ID re-presents it once the stall lifts
  assign take_jump = jump && !stall;
  assign redirect = br_taken || take_jump;
  assign pc_plus4 = pc + 32'd4;
  assign imem_addr = pc;
  always_comb begin
    pc_nxt = br_taken ? word_align(br_target) : take_jump ? word_align(jump_target) : (stall || !imem_ready) ? pc : pc_plus4;
    mode_nxt = (mode == RUN) ? ((!imem_ready && !redirect) ? WAIT_MEM : RUN) : ((imem_ready || redirect) ? RUN : WAIT_MEM);
  end
  always_ff @(posedge clk) begin
    pc <= rst ? RESET_PC : pc_nxt;
    mode <= rst ? RUN : mode_nxt;
  end
  assign ifid_d = '{instr: imem_rdata, pc_plus4: pc_plus4, valid: 1'b1};
  ifid_reg #(.NOP_INSTR(NOP_INSTR)) u_ifid (
    .clk    (clk),
    .rst    (rst),
    .flush  (redirect),
    .stall  (stall),
    .bubble (!imem_ready),
    .d      (ifid_d),
    .q      (ifid_q)
  );
  assign ifid_instr = ifid_q.instr;
  assign ifid_pc_plus4 = ifid_q.pc_plus4;
  assign ifid_valid = ifid_q.valid;
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: random and directed stimulus checked every cycle against a behavioural fetch model
module tb_if_stage;
  import if_stage_pkg::*;
  logic clk = 0, rst = 1, stall = 0, jump = 0, br_taken = 0, imem_ready = 1;
  logic [31:0] jump_target = 0, br_target = 0, junk = 0;
  logic [31:0] imem_addr, imem_rdata, pc, ifid_instr, ifid_pc_plus4;
  logic ifid_valid;
  logic [31:0] m_pc, m_instr, m_pp4;
  logic m_valid, m_pp4_known;
  logic chk_en = 0, lit_en = 0, lit_v = 0;
  logic [31:0] lit_pc = 0, lit_pp4 = 0;
  int n_chk = 0, n_fail = 0;
  if_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .jump          (jump),
    .jump_target   (jump_target),
    .br_taken      (br_taken),
    .br_target     (br_target),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_ready    (imem_ready),
    .pc            (pc),
    .ifid_instr    (ifid_instr),
    .ifid_pc_plus4 (ifid_pc_plus4),
    .ifid_valid    (ifid_valid)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[29:0], 2'b11} ^ 32'h1357_9BDF;
  endfunction
  assign imem_rdata = imem_ready ? mem_word(imem_addr) : junk;
  // reference: what the fetch stage must present after each edge
  always @(posedge clk) begin
    if (rst) begin
      m_pc <= RESET_PC_DEF; m_instr <= NOP_INSTR_DEF; m_pp4 <= 0; m_valid <= 0; m_pp4_known <= 1;
    end else if (br_taken || (jump && !stall)) begin
      m_pc <= (br_taken ? br_target : jump_target) & ~32'h3;
      m_instr <= NOP_INSTR_DEF; m_pp4 <= 0; m_valid <= 0; m_pp4_known <= 1;
    end else if (!stall && !imem_ready) begin
      m_instr <= NOP_INSTR_DEF; m_valid <= 0; m_pp4_known <= 0;
    end else if (!stall) begin
      m_pc <= m_pc + 4; m_instr <= mem_word(m_pc); m_pp4 <= m_pc + 4; m_valid <= 1; m_pp4_known <= 1;
    end
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (chk_en) begin
      check("pc", pc, m_pc);
      check("imem_addr", imem_addr, m_pc);
      check("ifid_instr", ifid_instr, m_instr);
      check("ifid_valid", {31'b0, ifid_valid}, {31'b0, m_valid});
      if (m_pp4_known) check("ifid_pc_plus4", ifid_pc_plus4, m_pp4);
    end
    if (lit_en) begin
      check("lit_pc", pc, lit_pc);
      check("lit_valid", {31'b0, ifid_valid}, {31'b0, lit_v});
      if (lit_v) check("lit_pc_plus4", ifid_pc_plus4, lit_pp4);
    end
  end
  task automatic step(input logic l, input logic [31:0] epc, input logic [31:0] epp4, input logic ev);
    lit_en = l; lit_pc = epc; lit_pp4 = epp4; lit_v = ev;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask
  initial begin
    step(0, 0, 0, 0);
    chk_en = 1;
    step(1, 32'h0, 0, 0);
    rst = 0;
    step(1, 32'h4, 32'h4, 1);
    step(1, 32'h8, 32'h8, 1);
    stall = 1;
    step(1, 32'h8, 32'h8, 1);
    step(1, 32'h8, 32'h8, 1);
    stall = 0;
    step(1, 32'hC, 32'hC, 1);
    jump = 1; jump_target = 32'h40;
    step(1, 32'h40, 0, 0);
    jump = 0;
    step(1, 32'h44, 32'h44, 1);
    br_taken = 1; br_target = 32'h100; stall = 1; jump = 1; jump_target = 32'h200;
    step(1, 32'h100, 0, 0);
    br_target = 32'h10; stall = 0; jump = 0;
    step(1, 32'h10, 0, 0);
    br_taken = 0; imem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      junk = $urandom;
      step(1, 32'h10, 0, 0);
    end
    imem_ready = 1;
    step(1, 32'h14, 32'h14, 1);
    br_taken = 1; br_target = 32'hFFFF_FFFC;
    step(1, 32'hFFFF_FFFC, 0, 0);
    br_taken = 0;
    step(1, 32'h0, 32'h0, 1);
    br_taken = 1; br_target = 32'h103;
    step(1, 32'h100, 0, 0);
    br_taken = 0; stall = 1;
    step(1, 32'h100, 0, 0);
    rst = 1;
    step(1, RESET_PC_DEF, 0, 0);
    rst = 0; stall = 0;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      stall = ($urandom_range(0, 4) == 0);
      jump = ($urandom_range(0, 7) == 0);
      br_taken = ($urandom_range(0, 9) == 0);
      imem_ready = ($urandom_range(0, 3) != 0);
      jump_target = $urandom;
      br_target = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      junk = $urandom;
      step(0, 0, 0, 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
